bsram_port_arbiter: RTL and testbench
=====================================

// Module: bsram_port_arbiter
// PURPOSE
//  Two-master front end for one port of a 16-bit dual-port block SRAM (1024 x 16 by default).
//  Arbitrates read/write requests from two bus masters (CPU data side, DMA/video) onto the single RAM port.
//  Tracks the RAM read latency and returns each read result to the master that issued it.
//  Sits directly upstream of the DP BSRAM wrapper and drives its ce/wre/ad/din/oce pins.
// PARAMETERS
//  A_SIZE    10    address width in words; depth = 2**A_SIZE
//  W_SIZE    16    data width in bits
//  READ_LAT  1     RAM read latency in cycles: 1 = bypass output reg, 2 = output reg enabled; only 1 and 2 are legal
// PORTS
//  clk        in   1       single clock for arbiter and RAM port
//  reset      in   1       synchronous, active-high reset
//  m0_req     in   1       master 0 request; held with cmd fields until m0_gnt
//  m0_we      in   1       master 0: 1 = write, 0 = read
//  m0_addr    in   A_SIZE  master 0 word address
//  m0_wdata   in   W_SIZE  master 0 write data
//  m0_gnt     out  1       master 0 request accepted this cycle (combinational)
//  m0_rvalid  out  1       master 0 read data valid (one-cycle pulse)
//  m0_rdata   out  W_SIZE  master 0 read data, meaningful only while m0_rvalid
//  m1_*       same set as m0_* for master 1
//  ram_ce     out  1       RAM port clock enable
//  ram_oce    out  1       RAM output-register enable
//  ram_wre    out  1       RAM write enable
//  ram_ad     out  A_SIZE  RAM address
//  ram_din    out  W_SIZE  RAM write data
//  ram_dout   in   W_SIZE  RAM read data
// BEHAVIOUR
//  - Arbitration:
//    - One command is issued per cycle at most; gnt is combinational from req and the RR pointer.
//    - Only one master requests: it is granted the same cycle.
//    - Both masters request: the master not granted last wins (round-robin).
//    - The RR pointer updates only on a grant; after reset it favours m0.
//    - No back-pressure: every cycle with a request produces a grant.
//  - RAM drive:
//    - ram_ce = (m0_gnt|m1_gnt).
//    - ram_wre, ram_ad and ram_din are muxed combinationally from the granted master; they are 0 when idle.
//    - ram_oce is 1 when READ_LAT = 2, otherwise 0.
//  - Read tracking:
//    - The tracker is a READ_LAT-deep shift register of {valid, owner}.
//    - A read granted in cycle N pulses the owner's rvalid in cycle N+READ_LAT.
//    - Writes produce no response.
//    - Back-to-back reads, including alternating owners, return in issue order with one rvalid per cycle.
//    - mX_rdata = ram_dout, unregistered.
//  - Hazards: no write-to-read forwarding. Same-address read-after-write ordering is the RAM's native behaviour.
//  - Reset (sync, active-high):
//    - While reset is high, gnt, rvalid, ram_ce and ram_wre are all 0.
//    - Reset clears the tracker and sets the RR pointer to m0.
//    - Reads in flight when reset asserts are dropped; no rvalid is produced for them after reset.
//  - An illegal READ_LAT value must stop elaboration via $error.
// TESTING
//  1. READ_LAT=1: m0 writes 0xBEEF to addr 0x005, then reads addr 0x005 -> m0_rvalid=1 with m0_rdata=0xBEEF exactly 1 cycle after the read grant; m1_rvalid stays 0.
//  2. m0 and m1 request continuously (reads) for 6 cycles -> grants alternate m0,m1,m0,m1,...; each read returns to its owner in order.
//  3. READ_LAT=2: preload addr 0x3FF=0x1234 and addr 0x000=0x5678; m1 reads addr 0x3FF then addr 0x000 back-to-back -> m1_rvalid high at N+2 and N+3 with 0x1234 then 0x5678; ram_oce=1.
//  4. Only m1 requests for 4 cycles (write addr 0x010..0x013 = 0xA0..0xA3) -> m1_gnt=1 every cycle, no rvalid; readback through m0 returns 0xA0..0xA3.
//  5. Assert reset for one cycle, one cycle after an m0 read grant with READ_LAT=2 -> no m0_rvalid; the first grant after reset goes to m0 when both masters request.
//  6. Idle (no req) -> ram_ce=0, ram_wre=0, ram_ad=0, no gnt or rvalid for 10 cycles.

Source files
------------

// File: rtl/bsram_port_arbiter.sv
// Two-master round-robin front end for one port of a dual-port block SRAM.
// Read results are steered back to the issuing master after READ_LAT cycles.
module bsram_port_arbiter #(
  parameter int A_SIZE   = 10,
  parameter int W_SIZE   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [A_SIZE-1:0] m0_addr,
  input  logic [W_SIZE-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [W_SIZE-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [A_SIZE-1:0] m1_addr,
  input  logic [W_SIZE-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [W_SIZE-1:0] m1_rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [A_SIZE-1:0] ram_ad,
  output logic [W_SIZE-1:0] ram_din,
  input  logic [W_SIZE-1:0] ram_dout
);

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("bsram_port_arbiter: READ_LAT must be 1 or 2 (got %0d)", READ_LAT);
  end

  // prio_q names the master that wins a tie; it points away from the last grantee.
  logic                prio_q, prio_d;
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [READ_LAT-1:0] own_q, own_d;
  logic                gnt0, gnt1;
  logic                issue_rd;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (m0_req && (!m1_req || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    if (gnt0) begin
      ram_wre = m0_we;
      ram_ad  = m0_addr;
      ram_din = m0_wdata;
    end else if (gnt1) begin
      ram_wre = m1_we;
      ram_ad  = m1_addr;
      ram_din = m1_wdata;
    end
  end

  always_comb begin
    issue_rd = (gnt0 & ~m0_we) | (gnt1 & ~m1_we);
    prio_d   = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
  end

  // Tracker stage 0 captures the read issued this cycle; the last stage lines up with ram_dout.
  always_comb begin
    vld_d    = vld_q;
    own_d    = own_q;
    vld_d[0] = issue_rd;
    own_d[0] = gnt1;
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
      vld_q  <= '0;
      own_q  <= '0;
    end else begin
      prio_q <= prio_d;
      vld_q  <= vld_d;
      own_q  <= own_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign ram_ce    = gnt0 | gnt1;
  assign ram_oce   = (READ_LAT == 2);
  assign m0_rvalid = ~reset & vld_q[READ_LAT-1] & ~own_q[READ_LAT-1];
  assign m1_rvalid = ~reset & vld_q[READ_LAT-1] &  own_q[READ_LAT-1];
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_bsram_port_arbiter.sv
// Bench for bsram_port_arbiter: one instance per legal READ_LAT, each with a behavioural BSRAM,
// read responses checked against a scoreboard of expected {owner, data, due cycle}.
module tb_bsram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;

  logic        m0_gnt_a, m0_rvalid_a, m1_gnt_a, m1_rvalid_a;
  logic [15:0] m0_rdata_a, m1_rdata_a;
  logic        ram_ce_a, ram_oce_a, ram_wre_a;
  logic [9:0]  ram_ad_a;
  logic [15:0] ram_din_a, ram_dout_a;

  logic        m0_gnt_b, m0_rvalid_b, m1_gnt_b, m1_rvalid_b;
  logic [15:0] m0_rdata_b, m1_rdata_b;
  logic        ram_ce_b, ram_oce_b, ram_wre_b;
  logic [9:0]  ram_ad_b;
  logic [15:0] ram_din_b, ram_dout_b;

  always #5 clk = ~clk;

  bsram_port_arbiter #(.A_SIZE(10), .W_SIZE(16), .READ_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_a), .m0_rvalid(m0_rvalid_a), .m0_rdata(m0_rdata_a),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt_a), .m1_rvalid(m1_rvalid_a), .m1_rdata(m1_rdata_a),
    .ram_ce(ram_ce_a), .ram_oce(ram_oce_a), .ram_wre(ram_wre_a),
    .ram_ad(ram_ad_a), .ram_din(ram_din_a), .ram_dout(ram_dout_a)
  );

  bsram_port_arbiter #(.A_SIZE(10), .W_SIZE(16), .READ_LAT(2)) u_dut_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_b), .m0_rvalid(m0_rvalid_b), .m0_rdata(m0_rdata_b),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt_b), .m1_rvalid(m1_rvalid_b), .m1_rdata(m1_rdata_b),
    .ram_ce(ram_ce_b), .ram_oce(ram_oce_b), .ram_wre(ram_wre_b),
    .ram_ad(ram_ad_b), .ram_din(ram_din_b), .ram_dout(ram_dout_b)
  );

  // Behavioural BSRAMs: synchronous read register, plus an output register on the latency-2 one.
  logic [15:0] mem_a [1024];
  logic [15:0] mem_b [1024];
  logic [15:0] rd1_a, rd1_b, rd2_b;

  always @(posedge clk) begin
    if (ram_ce_a) begin
      if (ram_wre_a) mem_a[ram_ad_a] <= ram_din_a;
      else           rd1_a <= mem_a[ram_ad_a];
    end
    if (ram_ce_b) begin
      if (ram_wre_b) mem_b[ram_ad_b] <= ram_din_b;
      else           rd1_b <= mem_b[ram_ad_b];
    end
    if (ram_oce_b) rd2_b <= rd1_b;
  end

  assign ram_dout_a = rd1_a;
  assign ram_dout_b = rd2_b;

  typedef struct {
    logic        owner;
    logic [15:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t     sbq [2][$];
  logic [15:0] shadow [1024];
  logic        exp_prio = 1'b0;
  logic        exp_g0, exp_g1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc++;

  // Reference arbiter: decides the grant for the current inputs and queues the expected read returns.
  task automatic model_issue();
    logic        we;
    logic [9:0]  a;
    logic [15:0] d;
    exp_g0 = 1'b0;
    exp_g1 = 1'b0;
    if (!reset) begin
      if (m0_req && (!m1_req || exp_prio == 1'b0)) exp_g0 = 1'b1;
      else if (m1_req)                             exp_g1 = 1'b1;
    end
    if (exp_g0 || exp_g1) begin
      we = exp_g0 ? m0_we    : m1_we;
      a  = exp_g0 ? m0_addr  : m1_addr;
      d  = exp_g0 ? m0_wdata : m1_wdata;
      if (we) begin
        shadow[a] = d;
      end else begin
        sbq[0].push_back('{owner: exp_g1, data: shadow[a], due: cyc + 1});
        sbq[1].push_back('{owner: exp_g1, data: shadow[a], due: cyc + 2});
      end
      exp_prio = exp_g0;
    end
    if (reset) begin
      exp_prio = 1'b0;
      sbq[0].delete();
      sbq[1].delete();
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  // Scoreboard monitor for both instances (index 0 = READ_LAT 1, index 1 = READ_LAT 2).
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [1:0]  rv;
      logic [1:0]  exp_rv;
      logic [15:0] got;
      rd_exp_t     head;
      rv = (d == 0) ? {m1_rvalid_a, m0_rvalid_a} : {m1_rvalid_b, m0_rvalid_b};
      if (rv !== 2'b00) begin
        checks++;
        if (sbq[d].size() == 0) begin
          errors++;
          $display("[TB] FAIL rvalid_unexpected lat=%0d cyc=%0d rvalid=%b required=00", d + 1, cyc, rv);
        end else begin
          head   = sbq[d].pop_front();
          exp_rv = head.owner ? 2'b10 : 2'b01;
          if (d == 0) got = head.owner ? m1_rdata_a : m0_rdata_a;
          else        got = head.owner ? m1_rdata_b : m0_rdata_b;
          if (rv !== exp_rv || got !== head.data || head.due != cyc) begin
            errors++;
            $display("[TB] FAIL read_return lat=%0d cyc=%0d rvalid=%b data=%h required rvalid=%b data=%h cyc=%0d",
                     d + 1, cyc, rv, got, exp_rv, head.data, head.due);
          end
        end
      end else if (sbq[d].size() != 0 && sbq[d][0].due <= cyc) begin
        checks++;
        errors++;
        head = sbq[d].pop_front();
        $display("[TB] FAIL read_missing lat=%0d cyc=%0d rvalid=00 required owner=%0d data=%h",
                 d + 1, cyc, head.owner, head.data);
      end
    end
  end

  task automatic test_reset();
    reset  = 1'b1;
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      model_issue();
      @(negedge clk);
      checks++;
      if ({m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b, ram_ce_a, ram_ce_b, ram_wre_a, ram_wre_b,
           m0_rvalid_a, m1_rvalid_a, m0_rvalid_b, m1_rvalid_b} !== 12'h000) begin
        errors++;
        $display("[TB] FAIL reset_outputs gnt_a=%b%b gnt_b=%b%b ce=%b%b wre=%b%b required all 0",
                 m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b, ram_ce_a, ram_ce_b, ram_wre_a, ram_wre_b);
      end
      next_cycle();
    end
    checks++;
    if ({ram_oce_a, ram_oce_b} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL ram_oce lat1=%b lat2=%b required 0/1", ram_oce_a, ram_oce_b);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h005; m0_wdata = 16'hBEEF;
    model_issue();
    @(negedge clk);
    checks++;
    if ({m0_gnt_a, m1_gnt_a, ram_ce_a, ram_wre_a, ram_ad_a, ram_din_a} !== {4'b1011, 10'h005, 16'hBEEF} ||
        {m0_gnt_b, m1_gnt_b, ram_wre_b, ram_ad_b} !== {3'b101, 10'h005}) begin
      errors++;
      $display("[TB] FAIL m0_write gnt=%b%b wre=%b ad=%h din=%h required 10/1/005/beef",
               m0_gnt_a, m1_gnt_a, ram_wre_a, ram_ad_a, ram_din_a);
    end
    next_cycle();
    m0_we = 1'b0;
    model_issue();
    @(negedge clk);
    checks++;
    if ({m0_gnt_a, ram_ce_a, ram_wre_a, ram_ad_a} !== {3'b110, 10'h005}) begin
      errors++;
      $display("[TB] FAIL m0_read_issue gnt=%b ce=%b wre=%b ad=%h required 1/1/0/005",
               m0_gnt_a, ram_ce_a, ram_wre_a, ram_ad_a);
    end
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      model_issue();
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if ({m0_rvalid_a, m1_rvalid_a, m0_rdata_a} !== {2'b10, 16'hBEEF}) begin
          errors++;
          $display("[TB] FAIL lat1_readback rvalid=%b%b data=%h required 10/beef",
                   m0_rvalid_a, m1_rvalid_a, m0_rdata_a);
        end
      end
      if (i == 1) begin
        checks++;
        if ({m0_rvalid_b, m1_rvalid_b, m0_rdata_b} !== {2'b10, 16'hBEEF}) begin
          errors++;
          $display("[TB] FAIL lat2_readback rvalid=%b%b data=%h required 10/beef",
                   m0_rvalid_b, m1_rvalid_b, m0_rdata_b);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    int i0;
    int i1;
    logic [3:0] pat;
    m1_req = 1'b1;
    m1_we  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m1_addr  = 10'h020 + 10'(i);
      m1_wdata = 16'h1100 + 16'(i);
      model_issue();
      @(negedge clk);
      checks++;
      if ({m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b} !== 4'b0101) begin
        errors++;
        $display("[TB] FAIL rr_preload gnt=%b%b%b%b required 0101", m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b);
      end
      next_cycle();
    end
    i0 = 0;
    i1 = 0;
    m1_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      m0_req  = (i0 < 3);
      m0_addr = 10'h020 + 10'(2 * i0);
      m1_req  = (i1 < 3);
      m1_addr = 10'h021 + 10'(2 * i1);
      model_issue();
      @(negedge clk);
      pat = (c % 2 == 0) ? 4'b1010 : 4'b0101;
      checks++;
      if ({m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b} !== pat) begin
        errors++;
        $display("[TB] FAIL rr_alternate c=%0d gnt=%b%b%b%b required %b", c,
                 m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b, pat);
      end
      next_cycle();
      if (exp_g0) i0++;
      if (exp_g1) i1++;
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      model_issue();
      next_cycle();
    end
  endtask

  task automatic test_lat2_back_to_back();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 10'h3FF; m0_wdata = 16'h1234;
    model_issue();
    next_cycle();
    m0_addr = 10'h000; m0_wdata = 16'h5678;
    model_issue();
    next_cycle();
    idle_inputs();
    m1_req = 1'b1; m1_addr = 10'h3FF;
    model_issue();
    next_cycle();
    m1_addr = 10'h000;
    model_issue();
    @(negedge clk);
    checks++;
    if (m1_gnt_b !== 1'b1 || ram_oce_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lat2_issue gnt=%b oce=%b required 1/1", m1_gnt_b, ram_oce_b);
    end
    next_cycle();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      model_issue();
      @(negedge clk);
      if (k < 2) begin
        checks++;
        if ({m1_rvalid_b, m0_rvalid_b, m1_rdata_b} !== {2'b10, (k == 0) ? 16'h1234 : 16'h5678}) begin
          errors++;
          $display("[TB] FAIL lat2_b2b k=%0d rvalid=%b%b data=%h required 10/%h", k,
                   m1_rvalid_b, m0_rvalid_b, m1_rdata_b, (k == 0) ? 16'h1234 : 16'h5678);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_single_master();
    m1_req = 1'b1;
    m1_we  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m1_addr  = 10'h010 + 10'(i);
      m1_wdata = 16'h00A0 + 16'(i);
      model_issue();
      @(negedge clk);
      checks++;
      if ({m0_gnt_a, m1_gnt_a, ram_wre_a, ram_ad_a, ram_din_a} !== {3'b011, m1_addr, m1_wdata} ||
          {m0_gnt_b, m1_gnt_b, ram_wre_b} !== 3'b011) begin
        errors++;
        $display("[TB] FAIL m1_only_write i=%0d gnt=%b%b wre=%b ad=%h din=%h required 01/1/%h/%h", i,
                 m0_gnt_a, m1_gnt_a, ram_wre_a, ram_ad_a, ram_din_a, m1_addr, m1_wdata);
      end
      next_cycle();
    end
    idle_inputs();
    m0_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 10'h010 + 10'(i);
      model_issue();
      @(negedge clk);
      checks++;
      if ({m0_gnt_a, m1_gnt_a, ram_ad_a} !== {2'b10, m0_addr}) begin
        errors++;
        $display("[TB] FAIL m0_readback_issue i=%0d gnt=%b%b ad=%h required 10/%h", i,
                 m0_gnt_a, m1_gnt_a, ram_ad_a, m0_addr);
      end
      next_cycle();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      model_issue();
      next_cycle();
    end
  endtask

  task automatic test_reset_inflight();
    m0_req = 1'b1; m0_addr = 10'h005;
    model_issue();
    next_cycle();
    reset  = 1'b1;
    m1_req = 1'b1; m1_addr = 10'h3FF;
    model_issue();
    @(negedge clk);
    checks++;
    if ({m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b, m0_rvalid_a, m0_rvalid_b} !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL reset_drop_n1 gnt=%b%b%b%b rvalid_a=%b rvalid_b=%b required all 0",
               m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b, m0_rvalid_a, m0_rvalid_b);
    end
    next_cycle();
    reset = 1'b0;
    model_issue();
    @(negedge clk);
    checks++;
    if ({m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b, m0_rvalid_b} !== 5'b10100) begin
      errors++;
      $display("[TB] FAIL reset_rr_m0 gnt=%b%b%b%b rvalid_b=%b required 1010/0",
               m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b, m0_rvalid_b);
    end
    next_cycle();
    m0_req = 1'b0;
    model_issue();
    @(negedge clk);
    checks++;
    if ({m0_gnt_a, m1_gnt_a} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_then_m1 gnt=%b%b required 01", m0_gnt_a, m1_gnt_a);
    end
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      model_issue();
      next_cycle();
    end
  endtask

  task automatic test_idle();
    idle_inputs();
    m0_we = 1'b1; m0_addr = 10'h155; m0_wdata = 16'hFFFF;
    m1_we = 1'b1; m1_addr = 10'h2AA; m1_wdata = 16'h5A5A;
    for (int i = 0; i < 10; i++) begin
      model_issue();
      @(negedge clk);
      checks++;
      if ({m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b, ram_ce_a, ram_wre_a, ram_ce_b, ram_wre_b,
           m0_rvalid_a, m1_rvalid_a, m0_rvalid_b, m1_rvalid_b, ram_ad_a, ram_ad_b} !== 32'h0) begin
        errors++;
        $display("[TB] FAIL idle i=%0d gnt=%b%b ce=%b wre=%b ad=%h ad_b=%h required all 0", i,
                 m0_gnt_a, m1_gnt_a, ram_ce_a, ram_wre_a, ram_ad_a, ram_ad_b);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_lat2_back_to_back();
    test_single_master();
    test_reset_inflight();
    test_idle();
    for (int i = 0; i < 3; i++) begin
      model_issue();
      next_cycle();
    end
    checks++;
    if (sbq[0].size() != 0 || sbq[1].size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain pending_lat1=%0d pending_lat2=%0d required 0/0",
               sbq[0].size(), sbq[1].size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
